// File: rtl/alu_branch_seq.sv
// alu_branch_seq: single-issue sequential ALU with branch-compare flags.
//
// Configuration macro: ALU_BRANCH_SEQ_MUL_EN
//   defined   -> opcode 111 runs an unsigned shift-add multiply, one
//                multiplier bit per cycle (WIDTH iterations).
//   undefined -> no MUL state or datapath; opcode 111 completes in one
//                cycle with result=0, zero=1, carry=0, branch_taken=0.
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; busy=0
// MUL    | shift-add iterations in progress (MUL build only)
// DONE   | done pulse; result/flags just updated; back to IDLE next
//
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 BEQ,
//          110 BLT (signed), 111 MUL.
module alu_branch_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             branch_taken
);

`ifdef ALU_BRANCH_SEQ_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_t;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_BEQ = 3'b101;
  localparam logic [2:0] OP_BLT = 3'b110;
`ifdef ALU_BRANCH_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam int         CW     = $clog2(WIDTH);
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             branch_q, branch_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_br;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;

`ifdef ALU_BRANCH_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_step;
  logic [CW-1:0]      cnt_q, cnt_d;
`endif

  // Single-cycle ALU evaluated straight from the operand inputs; its value
  // is captured only on the accepting edge.
  always_comb begin
    sum_ext   = {1'b0, A} + {1'b0, B};
    diff_ext  = {1'b0, A} - {1'b0, B};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_br    = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_BEQ: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_br    = (A == B);
      end
      OP_BLT: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_br    = ($signed(A) < $signed(B));
      end
      default: begin
        // Opcode 111 without a multiplier reads as a zero result.
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_br    = 1'b0;
      end
    endcase
  end

  // Next-state, result capture and multiply iteration.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    branch_d = branch_q;
`ifdef ALU_BRANCH_SEQ_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_BRANCH_SEQ_MUL_EN
          if (opcode == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH - 1);
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            carry_d  = alu_carry;
            branch_d = alu_br;
          end
`else
          state_d  = S_DONE;
          result_d = alu_res;
          zero_d   = (alu_res == '0);
          carry_d  = alu_carry;
          branch_d = alu_br;
`endif
        end
      end
`ifdef ALU_BRANCH_SEQ_MUL_EN
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        // Outputs stay frozen on the previous op until the product is final.
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = acc_step[WIDTH-1:0];
          zero_d   = (acc_step[WIDTH-1:0] == '0);
          carry_d  = |acc_step[2*WIDTH-1:WIDTH];
          branch_d = 1'b0;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset leaves a clean zero result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      branch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      branch_q <= branch_d;
    end
  end

`ifdef ALU_BRANCH_SEQ_MUL_EN
  // Multiplier working registers; reset discards any in-flight product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign result       = result_q;
  assign zero         = zero_q;
  assign carry        = carry_q;
  assign branch_taken = branch_q;

endmodule
